// File: rtl/vx_mem_rsp_arb.sv
// vx_mem_rsp_arb: N-to-1 memory response arbiter with per-channel FIFOs and a round-robin merge.
// Define VX_MEM_RSP_ARB_PERF_EN to add the perf_stall_cycles / perf_rsp_count counters.
module vx_mem_rsp_arb #(
  parameter int NUM_INPUTS    = 4,
  parameter int DATA_WIDTH    = 512,
  parameter int TAG_IN_WIDTH  = 8,
  parameter int BUF_DEPTH     = 2,
  parameter int SEL_WIDTH     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  parameter int TAG_OUT_WIDTH = TAG_IN_WIDTH + SEL_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_INPUTS-1:0]              in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   in_data,
  input  logic [NUM_INPUTS*TAG_IN_WIDTH-1:0] in_tag,
  output logic [NUM_INPUTS-1:0]              in_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [TAG_OUT_WIDTH-1:0]           out_tag,
  input  logic                               out_ready
`ifdef VX_MEM_RSP_ARB_PERF_EN
  ,
  output logic [31:0]                        perf_stall_cycles,
  output logic [31:0]                        perf_rsp_count
`endif
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Handshake: a beat moves on a rising clk edge when valid && ready. While valid && !ready the
  // sender holds its payload stable; this holds for every in_* channel and for the out_* port.

  logic [DATA_WIDTH-1:0]   buf_data [NUM_INPUTS][BUF_DEPTH];
  logic [TAG_IN_WIDTH-1:0] buf_tag  [NUM_INPUTS][BUF_DEPTH];
  logic [PTR_W-1:0]        wr_ptr     [NUM_INPUTS];
  logic [PTR_W-1:0]        rd_ptr     [NUM_INPUTS];
  logic [CNT_W-1:0]        count      [NUM_INPUTS];
  logic [CNT_W-1:0]        next_count [NUM_INPUTS];

  logic [NUM_INPUTS-1:0]   nonempty;
  logic [NUM_INPUTS-1:0]   push;
  logic [NUM_INPUTS-1:0]   pop;
  logic                    any_nonempty;
  logic                    load;
  logic [SEL_WIDTH-1:0]    rr;
  logic [SEL_WIDTH-1:0]    rr_next;
  logic [SEL_WIDTH-1:0]    grant;
  logic [DATA_WIDTH-1:0]   head_data;
  logic [TAG_IN_WIDTH-1:0] head_tag;

  assign any_nonempty = |nonempty;
  assign load         = !out_valid || out_ready;

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      nonempty[i] = (count[i] != '0);
      push[i]     = in_valid[i] && in_ready[i];
    end
  end

  // Scan from the highest offset down so the channel closest to rr (in wrap order) wins.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NUM_INPUTS) idx = idx - NUM_INPUTS;
      if (nonempty[SEL_WIDTH'(idx)]) grant = SEL_WIDTH'(idx);
    end
  end

  assign rr_next   = (grant == SEL_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;
  assign head_data = buf_data[grant][rd_ptr[grant]];
  assign head_tag  = buf_tag[grant][rd_ptr[grant]];

  always_comb begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pop[i]        = load && any_nonempty && (grant == SEL_WIDTH'(i));
      next_count[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  // Entry storage carries no reset: an entry is only read after count says it was written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (push[i]) begin
        buf_data[i][wr_ptr[i]] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
        buf_tag[i][wr_ptr[i]]  <= in_tag[i*TAG_IN_WIDTH +: TAG_IN_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
      in_ready  <= '0;
      rr        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
        count[i]    <= next_count[i];
        in_ready[i] <= (next_count[i] < CNT_W'(BUF_DEPTH));
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
      end
      if (load) begin
        if (any_nonempty) begin
          out_valid <= 1'b1;
          out_data  <= head_data;
          out_tag   <= {grant, head_tag};
          rr        <= rr_next;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef VX_MEM_RSP_ARB_PERF_EN
  // Stall counter saturates so long runs never alias to a small value; response count wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cycles <= '0;
      perf_rsp_count    <= '0;
    end else begin
      if (out_valid && !out_ready && (perf_stall_cycles != 32'hFFFF_FFFF))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (out_valid && out_ready)
        perf_rsp_count <= perf_rsp_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vx_mem_rsp_arb.sv
// tb_vx_mem_rsp_arb: randomized and directed bench for vx_mem_rsp_arb against a queue-based model.
// Also connects and checks the counters when VX_MEM_RSP_ARB_PERF_EN is defined.
module tb_vx_mem_rsp_arb;
  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int TW    = 8;
  localparam int DEPTH = 2;
  localparam int SW    = 2;
  localparam int TOW   = TW + SW;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    in_valid;
  logic [N*DW-1:0] in_data;
  logic [N*TW-1:0] in_tag;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [TOW-1:0]  out_tag;
  logic            out_ready;
`ifdef VX_MEM_RSP_ARB_PERF_EN
  logic [31:0]     perf_stall_cycles;
  logic [31:0]     perf_rsp_count;
`endif

  vx_mem_rsp_arb #(
    .NUM_INPUTS(N), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TW), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_tag(in_tag), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag), .out_ready(out_ready)
`ifdef VX_MEM_RSP_ARB_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_rsp_count(perf_rsp_count)
`endif
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- driver ----------------
  logic [DW-1:0] pend_d [N][$];
  logic [TW-1:0] pend_t [N][$];
  int            acc_cnt [N];
  int            rate     = 100;
  bit            rand_out = 1'b0;
  logic [N-1:0]  rdy_s;
  logic [DW-1:0] drop_d;
  logic [TW-1:0] drop_t;

  always begin
    @(negedge clk);
    rdy_s = in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i] && rdy_s[i] && reset_n) begin
        drop_d = pend_d[i].pop_front();
        drop_t = pend_t[i].pop_front();
        acc_cnt[i]++;
        in_valid[i] = 1'b0;
      end
      if (!in_valid[i] && pend_d[i].size() != 0 && $urandom_range(0, 99) < rate) begin
        in_valid[i]           = 1'b1;
        in_data[i*DW +: DW]   = pend_d[i][0];
        in_tag[i*TW +: TW]    = pend_t[i][0];
      end
    end
    if (rand_out) out_ready = ($urandom_range(0, 99) < 70);
  end

  // ---------------- behavioural model ----------------
  // Queues hold accepted-but-not-yet-presented responses; the output register is m_ov/m_od/m_ot.
  logic [DW-1:0]  mq_d [N][$];
  logic [TW-1:0]  mq_t [N][$];
  logic           m_ov   = 1'b0;
  logic [DW-1:0]  m_od   = '0;
  logic [TOW-1:0] m_ot   = '0;
  logic [N-1:0]   m_rdy  = '0;
  int             m_rr   = 0;
  logic [31:0]    m_stall = '0;
  logic [31:0]    m_rsp   = '0;
  int             m_g;
  bit             m_found;
  logic [N-1:0]   m_acc;
  logic [TW-1:0]  m_tag;

  always begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        mq_d[i].delete();
        mq_t[i].delete();
      end
      m_ov = 1'b0; m_od = '0; m_ot = '0; m_rdy = '0; m_rr = 0; m_stall = '0; m_rsp = '0;
    end else begin
      m_acc = in_valid & m_rdy;
      if (m_ov && out_ready) m_rsp = m_rsp + 32'd1;
      if (m_ov && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      if (!m_ov || out_ready) begin
        m_found = 1'b0;
        m_g     = 0;
        for (int k = 0; k < N; k++) begin
          if (!m_found && mq_d[(m_rr + k) % N].size() != 0) begin
            m_found = 1'b1;
            m_g     = (m_rr + k) % N;
          end
        end
        if (m_found) begin
          m_od  = mq_d[m_g].pop_front();
          m_tag = mq_t[m_g].pop_front();
          m_ot  = {SW'(m_g), m_tag};
          m_ov  = 1'b1;
          m_rr  = (m_g + 1) % N;
        end else begin
          m_ov = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (m_acc[i]) begin
          mq_d[i].push_back(in_data[i*DW +: DW]);
          mq_t[i].push_back(in_tag[i*TW +: TW]);
        end
      end
      for (int i = 0; i < N; i++) m_rdy[i] = (mq_d[i].size() < DEPTH);
    end
  end

  // ---------------- compare + scoreboard ----------------
  logic [TOW-1:0] exp_q [$];
  logic [TOW-1:0] exp_tag;
  bit cmp_en = 1'b0;
  bit sb_en  = 1'b0;
  int cyc = 0, hs_cnt = 0, first_hs = 0, last_hs = 0;

  always begin
    @(negedge clk);
    cyc++;
    if (cmp_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("out_data",  64'(out_data),  64'(m_od));
      chk("out_tag",   64'(out_tag),   64'(m_ot));
      chk("in_ready",  64'(in_ready),  64'(m_rdy));
`ifdef VX_MEM_RSP_ARB_PERF_EN
      chk("perf_stall_cycles", 64'(perf_stall_cycles), 64'(m_stall));
      chk("perf_rsp_count",    64'(perf_rsp_count),    64'(m_rsp));
`endif
    end
    if (sb_en && reset_n && out_valid && out_ready) begin
      hs_cnt++;
      if (hs_cnt == 1) first_hs = cyc;
      last_hs = cyc;
      chk("sb_expected_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_tag = exp_q.pop_front();
        chk("sb_tag_order", 64'(out_tag), 64'(exp_tag));
      end
    end
  end

  // ---------------- helper tasks ----------------
  function automatic bit tb_idle();
    bit r = 1'b1;
    for (int i = 0; i < N; i++)
      if (pend_d[i].size() != 0 || mq_d[i].size() != 0) r = 1'b0;
    if (in_valid != '0 || m_ov) r = 1'b0;
    return r;
  endfunction

  task automatic wait_acc(input int ch, input int n, input int budget);
    int k = 0;
    while (acc_cnt[ch] < n && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    chk($sformatf("accept_ch%0d_reached", ch), 64'(acc_cnt[ch] >= n), 64'd1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    while (!tb_idle() && k < budget) begin
      @(posedge clk); #2;
      k++;
    end
    chk(name, 64'(tb_idle()), 64'd1);
  endtask

  task automatic clear_driver();
    for (int i = 0; i < N; i++) begin
      pend_d[i].delete();
      pend_t[i].delete();
    end
    in_valid = '0;
    rand_out = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    clear_driver();
    out_ready = 1'b0;
    reset_n   = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(posedge clk); #2;
  endtask

  task automatic add_item(input int ch, input logic [DW-1:0] d, input logic [TW-1:0] t, input bit track);
    pend_d[ch].push_back(d);
    pend_t[ch].push_back(t);
    if (track) exp_q.push_back({SW'(ch), t});
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] d_single, d_first;
  int base, stale, k;

  initial begin
    in_valid = '0; in_data = '0; in_tag = '0; out_ready = 1'b0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    cmp_en = 1'b1;
    #2 reset_n = 1'b1;

    // Reset then idle: in_ready rises on the first edge after release.
    @(negedge clk);
    chk("idle_in_ready_before_edge", 64'(in_ready), 64'h0);
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'hF);
    chk("idle_out_valid", 64'(out_valid), 64'h0);
    chk("idle_out_tag", 64'(out_tag), 64'h0);

    // Single response on channel 2.
    @(posedge clk); #2;
    out_ready = 1'b1;
    rate      = 100;
    d_single  = $urandom;
    add_item(2, d_single, 8'h5A, 1'b0);
    wait_acc(2, 1, 20);
    @(negedge clk);
    chk("single_valid_before_e1", 64'(out_valid), 64'h0);
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'h1);
    chk("single_tag", 64'(out_tag), 64'h25A);
    chk("single_data", 64'(out_data), 64'(d_single));
    @(negedge clk);
    chk("single_valid_drop", 64'(out_valid), 64'h0);

    // Round-robin from a fresh pointer: 3 per channel, expect 0,1,2,3 x3 back to back.
    do_reset();
    exp_q.delete();
    hs_cnt = 0;
    sb_en  = 1'b1;
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < N; c++)
        add_item(c, $urandom, TW'(c * 16 + r), 1'b1);
    wait_drain("rr_drain", 200);
    @(negedge clk);
    sb_en = 1'b0;
    chk("rr_handshakes", 64'(hs_cnt), 64'd12);
    chk("rr_no_bubbles", 64'(last_hs - first_hs), 64'd11);
    chk("rr_exp_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: channel 0 fills output register plus both buffer entries.
    @(posedge clk); #2;
    out_ready = 1'b0;
    hs_cnt    = 0;
    sb_en     = 1'b1;
    base      = acc_cnt[0];
    d_first   = $urandom;
    add_item(0, d_first, 8'hA0, 1'b1);
    for (int j = 1; j < 5; j++) add_item(0, $urandom, TW'(8'hA0 + j), 1'b1);
    wait_acc(0, base + 3, 30);
    @(negedge clk);
    chk("bp_in_ready0_full", 64'(in_ready[0]), 64'h0);
    chk("bp_out_valid", 64'(out_valid), 64'h1);
    chk("bp_out_data_head", 64'(out_data), 64'(d_first));
    repeat (3) @(negedge clk);
    chk("bp_out_data_stable", 64'(out_data), 64'(d_first));
    chk("bp_no_extra_accept", 64'(acc_cnt[0] - base), 64'd3);
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_in_ready0_still_low", 64'(in_ready[0]), 64'h0);
    @(negedge clk);
    chk("bp_in_ready0_restored", 64'(in_ready[0]), 64'h1);
    wait_drain("bp_drain", 100);
    @(negedge clk);
    sb_en = 1'b0;
    chk("bp_handshakes", 64'(hs_cnt), 64'd5);
    chk("bp_exp_empty", 64'(exp_q.size()), 64'd0);

    // Streaming on channel 1: simultaneous push/pop keeps in_ready high, pointers wrap.
    @(posedge clk); #2;
    hs_cnt = 0;
    sb_en  = 1'b1;
    base   = acc_cnt[1];
    for (int j = 0; j < 10; j++) add_item(1, $urandom, TW'(8'hC0 + j), 1'b1);
    k = 0;
    while (acc_cnt[1] - base < 10 && k < 60) begin
      @(negedge clk);
      k++;
      if (acc_cnt[1] - base >= 1) chk("stream_in_ready1", 64'(in_ready[1]), 64'h1);
    end
    chk("stream_accepts", 64'(acc_cnt[1] - base), 64'd10);
    wait_drain("stream_drain", 100);
    @(negedge clk);
    sb_en = 1'b0;
    chk("stream_handshakes", 64'(hs_cnt), 64'd10);

    // Randomized traffic with random backpressure, checked every cycle against the model.
    @(posedge clk); #2;
    rate     = 60;
    rand_out = 1'b1;
    for (int j = 0; j < 40; j++)
      for (int c = 0; c < N; c++)
        add_item(c, $urandom, TW'($urandom_range(0, 255)), 1'b0);
    wait_drain("random_drain", 3000);
    rand_out  = 1'b0;
    out_ready = 1'b1;
    rate      = 100;

    // Mid-operation reset with 5 buffered entries plus one in the output register.
    do_reset();
    base = acc_cnt[0];
    add_item(0, $urandom, 8'h01, 1'b0);
    add_item(0, $urandom, 8'h02, 1'b0);
    add_item(0, $urandom, 8'h03, 1'b0);
    add_item(1, $urandom, 8'h11, 1'b0);
    add_item(1, $urandom, 8'h12, 1'b0);
    add_item(2, $urandom, 8'h21, 1'b0);
    wait_acc(0, base + 3, 30);
    @(negedge clk);
    chk("pre_reset_in_ready", 64'(in_ready), 64'hC);
    chk("pre_reset_out_valid", 64'(out_valid), 64'h1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_out_valid", 64'(out_valid), 64'h0);
    chk("async_reset_in_ready", 64'(in_ready), 64'h0);
    chk("async_reset_out_tag", 64'(out_tag), 64'h0);
    chk("async_reset_out_data", 64'(out_data), 64'h0);
`ifdef VX_MEM_RSP_ARB_PERF_EN
    chk("async_reset_perf_stall", 64'(perf_stall_cycles), 64'h0);
    chk("async_reset_perf_rsp", 64'(perf_rsp_count), 64'h0);
`endif
    clear_driver();
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_after_reset", 64'(stale), 64'd0);
    chk("post_reset_in_ready", 64'(in_ready), 64'hF);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", passes, checks);
    $fatal(1, "watchdog");
  end

endmodule
